flappy_core: RTL and testbench

Parametrised game engine for the flappy-bird design, replacing the fixed three-pipe controller. Owns the game state machine, bird physics, N scrolling pipes with LFSR-randomised gaps, collision detection and a BCD score. Drives the packed bird/pipe/score/status bus consumed by the display path and is advanced once per frame by a frame tick.

---
 rtl/flappy_pkg.sv | 49 ++++
 rtl/pipe_channel.sv | 57 +++++
 rtl/flappy_core.sv | 161 ++++++++++++++++
 tb/tb_flappy_core.sv | 222 ++++++++++++++++++++++
 4 files changed

// File: rtl/flappy_pkg.sv
// Shared constants and helpers for the flappy game engine: status codes,
// pipe bus record layout, gap LFSR and BCD score arithmetic.
package flappy_pkg;

  localparam logic [1:0] ST_READY = 2'd0;
  localparam logic [1:0] ST_PLAY  = 2'd1;
  localparam logic [1:0] ST_DEAD  = 2'd2;

  localparam int unsigned PIPE_REC_W   = 32;
  localparam int unsigned PIPE_GAP_LSB = 0;
  localparam int unsigned PIPE_X_LSB   = 16;
  localparam int unsigned GAP_MIN      = 40;

  // 16-bit Fibonacci LFSR, taps 16,14,13,11
  function automatic logic [15:0] lfsr_step(input logic [15:0] l);
    return {l[14:0], l[15] ^ l[13] ^ l[12] ^ l[10]};
  endfunction

  function automatic logic [15:0] lfsr_advance(input logic [15:0] l, input int unsigned n);
    logic [15:0] r;
    r = l;
    for (int unsigned k = 0; k < n; k++) r = lfsr_step(r);
    return r;
  endfunction

  function automatic logic [15:0] gap_of(input logic [15:0] l, input int unsigned range);
    return 16'(GAP_MIN + (32'(l) % range));
  endfunction

  // Four-digit BCD increment, saturating at 9999
  function automatic logic [15:0] bcd_inc(input logic [15:0] s);
    logic [15:0] r;
    logic        c;
    r = s;
    c = 1'b1;
    if (s == 16'h9999) return s;
    for (int d = 0; d < 4; d++) begin
      if (c) begin
        if (r[4*d +: 4] == 4'd9) r[4*d +: 4] = 4'd0;
        else begin
          r[4*d +: 4] = r[4*d +: 4] + 4'd1;
          c = 1'b0;
        end
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/pipe_channel.sv
// One scrolling pipe: position/gap registers plus wrap, score and hit terms
// evaluated against the post-scroll position.
module pipe_channel #(
  parameter int unsigned SPEED    = 2,
  parameter int unsigned WRAP_ADD = 670,
  parameter int unsigned PIPE_W   = 52,
  parameter int unsigned BIRD_X   = 160,
  parameter int unsigned BIRD_W   = 24,
  parameter int unsigned BIRD_H   = 24,
  parameter int unsigned GAP_H    = 120,
  parameter int unsigned INIT_X   = 640,
  parameter logic [15:0] INIT_GAP = 16'd40
) (
  input  logic        clk,
  input  logic        clr,
  input  logic        step,
  input  logic        reinit,
  input  logic [15:0] new_gap,
  input  logic [15:0] bird_y_next,
  output logic [15:0] x,
  output logic [15:0] gap_top,
  output logic        wrap_c,
  output logic        scored_c,
  output logic        hit_c
);

  logic [15:0] x_next, gap_next;
  logic [16:0] old_right, new_right;
  logic        overlap_x, outside_gap;

  assign wrap_c    = (x <= 16'(SPEED));
  assign x_next    = wrap_c ? x + 16'(WRAP_ADD) : x - 16'(SPEED);
  assign gap_next  = wrap_c ? new_gap : gap_top;
  assign old_right = 17'(x) + 17'(PIPE_W);
  assign new_right = 17'(x_next) + 17'(PIPE_W);

  // Right edge crosses the bird's left edge on this scroll step
  assign scored_c    = (old_right >= 17'(BIRD_X)) && (new_right < 17'(BIRD_X));
  assign overlap_x   = (x_next < 16'(BIRD_X + BIRD_W)) && (new_right > 17'(BIRD_X));
  assign outside_gap = (bird_y_next < gap_next) ||
                       ((17'(bird_y_next) + 17'(BIRD_H)) > (17'(gap_next) + 17'(GAP_H)));
  assign hit_c       = overlap_x && outside_gap;

  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      x       <= 16'(INIT_X);
      gap_top <= INIT_GAP;
    end else if (reinit) begin
      x       <= 16'(INIT_X);
      gap_top <= new_gap;
    end else if (step) begin
      x       <= x_next;
      gap_top <= gap_next;
    end
  end

endmodule

// File: rtl/flappy_core.sv
// Frame-ticked flappy game engine: FSM, bird physics, LFSR gap generator,
// N pipe channels, collision resolution and BCD score.
module flappy_core
  import flappy_pkg::*;
#(
  parameter int unsigned N_PIPES   = 3,
  parameter int unsigned SCREEN_W  = 640,
  parameter int unsigned SCREEN_H  = 480,
  parameter int unsigned PIPE_W    = 52,
  parameter int unsigned GAP_H     = 120,
  parameter int unsigned SPACING   = 224,
  parameter int unsigned BIRD_X    = 160,
  parameter int unsigned BIRD_W    = 24,
  parameter int unsigned BIRD_H    = 24,
  parameter int unsigned SPEED     = 2,
  parameter int unsigned GRAVITY   = 1,
  parameter int unsigned FLAP_V    = 8,
  parameter int unsigned VMAX      = 10,
  parameter int unsigned DEAD_HOLD = 30,
  parameter logic [15:0] LFSR_SEED = 16'hACE1
) (
  input  logic                           clk,
  input  logic                           clr,
  input  logic                           frame_tick,
  input  logic                           flap,
  output logic [1:0]                     status,
  output logic [15:0]                    score,
  output logic [15:0]                    bird_y,
  output logic [PIPE_REC_W*N_PIPES-1:0]  pipes
);

  localparam int unsigned       FLOOR     = SCREEN_H - BIRD_H;
  localparam int unsigned       START_Y   = FLOOR / 2;
  localparam int unsigned       GAP_RANGE = SCREEN_H - GAP_H - 80;
  localparam int unsigned       WRAP_ADD  = N_PIPES * SPACING - SPEED;
  localparam logic [15:0]       LFSR_INIT = lfsr_advance(LFSR_SEED, N_PIPES);
  localparam logic signed [7:0] VEL_FLAP  = 8'(32'd0 - FLAP_V);
  localparam logic signed [7:0] VEL_MAX   = 8'(VMAX);
  localparam logic signed [7:0] VEL_GRAV  = 8'(GRAVITY);
  localparam logic signed [17:0] FLOOR_S  = 18'(FLOOR);

  logic [1:0]         state, state_n;
  logic signed [7:0]  vel, vel_n, vel_c, vel_sum;
  logic signed [17:0] y_sum;
  logic [15:0]        bird_y_n, y_c, score_n, dead_cnt, cnt_n, lfsr, lfsr_last;
  logic               flap_prev, flap_req, flap_req_n;
  logic               rise_c, req_c, play_step_c, reinit_c, collide_c;
  logic [N_PIPES-1:0] wrap_v, scored_v, hit_v;

  assign status = state;
  assign rise_c = flap & ~flap_prev;
  assign req_c  = flap_req | rise_c;

  // A flap in READY starts the game and takes the first physics step on the same tick
  assign play_step_c = frame_tick && ((state == ST_PLAY) || (state == ST_READY && req_c));
  assign reinit_c    = frame_tick && (state == ST_DEAD) && req_c && (dead_cnt >= 16'(DEAD_HOLD));

  // Bird physics for the candidate step
  always_comb begin
    vel_sum = vel + VEL_GRAV;
    vel_c   = req_c ? VEL_FLAP : ((vel_sum > VEL_MAX) ? VEL_MAX : vel_sum);
    y_sum   = $signed({2'b00, bird_y}) + 18'(vel_c);
    if (y_sum[17])             y_c = '0;
    else if (y_sum > FLOOR_S)  y_c = 16'(FLOOR);
    else                       y_c = y_sum[15:0];
  end

  // LFSR chain: each reinitialised or wrapping channel takes the next step in index order
  for (genvar i = 0; i < N_PIPES; i++) begin : g_ch
    logic [15:0] l_in, l_out, gap_new, x, gap;
    if (i == 0) begin : g_head
      assign l_in = lfsr;
    end else begin : g_link
      assign l_in = g_ch[i-1].l_out;
    end
    assign l_out   = (reinit_c || (play_step_c && wrap_v[i])) ? lfsr_step(l_in) : l_in;
    assign gap_new = gap_of(l_out, GAP_RANGE);

    pipe_channel #(
      .SPEED    (SPEED),
      .WRAP_ADD (WRAP_ADD),
      .PIPE_W   (PIPE_W),
      .BIRD_X   (BIRD_X),
      .BIRD_W   (BIRD_W),
      .BIRD_H   (BIRD_H),
      .GAP_H    (GAP_H),
      .INIT_X   (SCREEN_W + 32'(i) * SPACING),
      .INIT_GAP (gap_of(lfsr_advance(LFSR_SEED, 32'(i) + 32'd1), GAP_RANGE))
    ) u_pipe (
      .clk         (clk),
      .clr         (clr),
      .step        (play_step_c),
      .reinit      (reinit_c),
      .new_gap     (gap_new),
      .bird_y_next (y_c),
      .x           (x),
      .gap_top     (gap),
      .wrap_c      (wrap_v[i]),
      .scored_c    (scored_v[i]),
      .hit_c       (hit_v[i])
    );

    assign pipes[PIPE_REC_W*i + PIPE_X_LSB   +: 16] = x;
    assign pipes[PIPE_REC_W*i + PIPE_GAP_LSB +: 16] = gap;
  end

  assign lfsr_last = g_ch[N_PIPES-1].l_out;
  assign collide_c = (y_c == 16'(FLOOR)) || (|hit_v);

  // Next-state and datapath updates; collision takes priority over scoring
  always_comb begin
    state_n    = state;
    vel_n      = vel;
    bird_y_n   = bird_y;
    score_n    = score;
    cnt_n      = dead_cnt;
    flap_req_n = frame_tick ? 1'b0 : req_c;
    if (play_step_c) begin
      vel_n    = vel_c;
      bird_y_n = y_c;
      if (collide_c) begin
        state_n = ST_DEAD;
        cnt_n   = '0;
      end else begin
        state_n = ST_PLAY;
        if (|scored_v) score_n = bcd_inc(score);
      end
    end else if (reinit_c) begin
      state_n  = ST_READY;
      vel_n    = '0;
      bird_y_n = 16'(START_Y);
      score_n  = '0;
      cnt_n    = '0;
    end else if (frame_tick && state == ST_DEAD && dead_cnt < 16'(DEAD_HOLD)) begin
      cnt_n = dead_cnt + 16'd1;
    end
  end

  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      state     <= ST_READY;
      vel       <= '0;
      bird_y    <= 16'(START_Y);
      score     <= '0;
      dead_cnt  <= '0;
      lfsr      <= LFSR_INIT;
      flap_prev <= 1'b0;
      flap_req  <= 1'b0;
    end else begin
      state     <= state_n;
      vel       <= vel_n;
      bird_y    <= bird_y_n;
      score     <= score_n;
      dead_cnt  <= cnt_n;
      lfsr      <= lfsr_last;
      flap_prev <= flap;
      flap_req  <= flap_req_n;
    end
  end

endmodule

// File: tb/tb_flappy_core.sv
// Self-checking bench for flappy_core: directed game scenarios plus
// randomized play checked every cycle against an integer game model.
module tb_flappy_core;
  import flappy_pkg::*;

  localparam int NP = 3;

  logic            clk = 1'b0;
  logic            clr, frame_tick, flap;
  logic [1:0]      status;
  logic [15:0]     score, bird_y;
  logic [32*NP-1:0] pipes;

  flappy_core dut (
    .clk        (clk),
    .clr        (clr),
    .frame_tick (frame_tick),
    .flap       (flap),
    .status     (status),
    .score      (score),
    .bird_y     (bird_y),
    .pipes      (pipes)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  // Game model in plain integers
  int          m_st, m_y, m_vel, m_score, m_cnt;
  int          m_x [NP];
  int          m_gap [NP];
  logic [15:0] m_lfsr;
  bit          m_req, m_prev;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, want %0h", name, act, exp);
  endtask

  function automatic logic [15:0] nxt(input logic [15:0] l);
    return {l[14:0], l[15] ^ l[13] ^ l[12] ^ l[10]};
  endfunction

  function automatic logic [15:0] to_bcd(input int v);
    return {4'(v / 1000), 4'((v / 100) % 10), 4'((v / 10) % 10), 4'(v % 10)};
  endfunction

  task automatic model_init_pipes();
    for (int i = 0; i < NP; i++) begin
      m_lfsr   = nxt(m_lfsr);
      m_gap[i] = 40 + int'(m_lfsr) % 280;
      m_x[i]   = 640 + 224 * i;
    end
  endtask

  task automatic model_reset();
    m_st = 0; m_y = 228; m_vel = 0; m_score = 0; m_cnt = 0;
    m_req = 0; m_prev = 0; m_lfsr = 16'hACE1;
    model_init_pipes();
  endtask

  task automatic model_play(input bit req);
    bit hit, scored;
    int old;
    m_vel = req ? -8 : ((m_vel + 1 > 10) ? 10 : m_vel + 1);
    m_y   = m_y + m_vel;
    if (m_y < 0) m_y = 0;
    if (m_y > 456) m_y = 456;
    hit    = (m_y == 456);
    scored = 0;
    for (int i = 0; i < NP; i++) begin
      old = m_x[i];
      if (old <= 2) begin
        m_x[i]   = old + 3 * 224 - 2;
        m_lfsr   = nxt(m_lfsr);
        m_gap[i] = 40 + int'(m_lfsr) % 280;
      end else m_x[i] = old - 2;
      if (old + 52 >= 160 && m_x[i] + 52 < 160) scored = 1;
      if (m_x[i] < 184 && m_x[i] + 52 > 160 &&
          (m_y < m_gap[i] || m_y + 24 > m_gap[i] + 120)) hit = 1;
    end
    if (hit) begin
      m_st = 2; m_cnt = 0;
    end else begin
      m_st = 1;
      if (scored && m_score < 9999) m_score++;
    end
  endtask

  task automatic model_clock(input bit tick, input bit fl);
    bit req;
    req    = m_req || (fl && !m_prev);
    m_prev = fl;
    if (!tick) begin
      m_req = req;
      return;
    end
    m_req = 0;
    if (m_st == 1 || (m_st == 0 && req)) model_play(req);
    else if (m_st == 2) begin
      if (req && m_cnt >= 30) begin
        m_st = 0; m_y = 228; m_vel = 0; m_score = 0; m_cnt = 0;
        model_init_pipes();
      end else if (m_cnt < 30) m_cnt++;
    end
  endtask

  task automatic compare_all();
    logic [32*NP-1:0] ep;
    for (int i = 0; i < NP; i++) ep[32*i +: 32] = {16'(m_x[i]), 16'(m_gap[i])};
    chk("status", 128'(status), 128'(m_st));
    chk("score",  128'(score),  128'(to_bcd(m_score)));
    chk("bird_y", 128'(bird_y), 128'(m_y));
    chk("pipes",  128'(pipes),  128'(ep));
  endtask

  task automatic cyc(input bit tick, input bit fl);
    frame_tick = tick;
    flap       = fl;
    model_clock(tick, fl);
    @(negedge clk);
    compare_all();
  endtask

  task automatic mid_reset();
    frame_tick = 1'b0;
    flap       = 1'b0;
    #1 clr = 1'b0;
    #1 model_reset();
    compare_all();
    chk("midrst_status", 128'(status), 128'd0);
    @(negedge clk);
    compare_all();
    clr = 1'b1;
  endtask

  function automatic int target_gap();
    int bx, g;
    bx = 100000;
    g  = 200;
    for (int i = 0; i < NP; i++)
      if (m_x[i] + 52 >= 150 && m_x[i] < bx) begin
        bx = m_x[i];
        g  = m_gap[i];
      end
    return g;
  endfunction

  initial begin
    int  k;
    bit  want, tk;
    clr = 1'b1; frame_tick = 1'b0; flap = 1'b0;
    model_reset();
    #1 clr = 1'b0;
    #1 compare_all();
    chk("rst_status", 128'(status), 128'd0);
    chk("rst_bird",   128'(bird_y), 128'd228);
    chk("rst_score",  128'(score),  128'd0);
    chk("rst_x0",     128'(pipes[31:16]), 128'd640);
    chk("rst_x1",     128'(pipes[63:48]), 128'd864);
    chk("rst_x2",     128'(pipes[95:80]), 128'd1088);
    @(negedge clk);
    clr = 1'b1;

    repeat (100) cyc(1'b1, 1'b0);
    chk("idle_status", 128'(status), 128'd0);
    chk("idle_bird",   128'(bird_y), 128'd228);
    chk("idle_x0",     128'(pipes[31:16]), 128'd640);
    chk("idle_x2",     128'(pipes[95:80]), 128'd1088);

    cyc(1'b1, 1'b1);
    chk("start_status", 128'(status), 128'd1);
    chk("start_bird",   128'(bird_y), 128'd220);
    repeat (9) cyc(1'b1, 1'b0);
    chk("arc_bird", 128'(bird_y), 128'd193);
    chk("arc_x0",   128'(pipes[31:16]), 128'd620);

    k = 0;
    while (m_st != 2 && k < 300) begin
      cyc(1'b1, 1'b0);
      k++;
    end
    chk("fall_status", 128'(status), 128'd2);
    chk("fall_bird",   128'(bird_y), 128'd456);
    chk("fall_score",  128'(score),  128'd0);

    for (int t = 1; t <= 31; t++) begin
      cyc(1'b1, (t == 10 || t == 31));
      if (t == 10) chk("dead_early", 128'(status), 128'd2);
      if (t == 30) begin
        chk("dead_hold",   128'(status), 128'd2);
        chk("dead_frozen", 128'(bird_y), 128'd456);
      end
    end
    chk("restart_status", 128'(status), 128'd0);
    chk("restart_score",  128'(score),  128'd0);
    chk("restart_bird",   128'(bird_y), 128'd228);

    chk("bcd_sat",   128'(bcd_inc(16'h9999)), 128'h9999);
    chk("bcd_carry", 128'(bcd_inc(16'h0199)), 128'h0200);
    chk("bcd_step",  128'(bcd_inc(16'h1234)), 128'h1235);

    for (int c = 0; c < 16000; c++) begin
      if (c == 6000 || c == 12000) mid_reset();
      tk = ($urandom_range(0, 9) < 7);
      if (m_st == 1) begin
        want = (m_y > target_gap() + 60) && (m_vel >= 0);
        if ($urandom_range(0, 15) == 0) want = !want;
      end else begin
        want = ($urandom_range(0, 19) == 0);
      end
      cyc(tk, want && (flap == 1'b0));
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
